// File: rtl/input_conditioner.sv
// Input conditioner: synchronises, debounces and edge-detects the raw run/step/valid
// switches and the 5-bit data bus so that every downstream input is clean and clk-synchronous.
module input_conditioner #(
   parameter int DEBOUNCE_CYCLES = 250000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       run,
   input  logic       step,
   input  logic       valid,
   input  logic [4:0] in,
   output logic       run_lvl,
   output logic       step_lvl,
   output logic       step_pulse,
   output logic       valid_lvl,
   output logic       valid_pulse,
   output logic [4:0] in_lvl,
   output logic       in_changed
);

   localparam int NCH = 8;
   localparam int CW  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   // Channel order: 0 run, 1 step, 2 valid, 3..7 in[0..4]
   logic [NCH-1:0] raw;
   assign raw = {in, valid, step, run};

   logic [NCH-1:0] s1_q, s1_d;
   logic [NCH-1:0] s2_q, s2_d;
   logic [NCH-1:0] lvl_q, lvl_d;
   logic [NCH-1:1] lvl_dly_q, lvl_dly_d;
   logic [CW-1:0]  cnt_q [NCH];
   logic [CW-1:0]  cnt_d [NCH];
   logic           step_pulse_q, step_pulse_d;
   logic           valid_pulse_q, valid_pulse_d;
   logic           in_changed_q, in_changed_d;

   always_comb begin
      s1_d      = raw;
      s2_d      = s1_q;
      lvl_d     = lvl_q;
      lvl_dly_d = lvl_q[NCH-1:1];
      for (int i = 0; i < NCH; i++) begin
         cnt_d[i] = '0;
         // Any return to the stable level restarts the hold count.
         if (s2_q[i] == lvl_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CNT_MAX) begin
            lvl_d[i] = s2_q[i];
            cnt_d[i] = '0;
         end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
         end
      end
      step_pulse_d  = lvl_q[1] & ~lvl_dly_q[1];
      valid_pulse_d = lvl_q[2] & ~lvl_dly_q[2];
      in_changed_d  = |(lvl_q[7:3] ^ lvl_dly_q[7:3]);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q          <= '0;
         s2_q          <= '0;
         lvl_q         <= '0;
         lvl_dly_q     <= '0;
         step_pulse_q  <= 1'b0;
         valid_pulse_q <= 1'b0;
         in_changed_q  <= 1'b0;
         for (int i = 0; i < NCH; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         s1_q          <= s1_d;
         s2_q          <= s2_d;
         lvl_q         <= lvl_d;
         lvl_dly_q     <= lvl_dly_d;
         step_pulse_q  <= step_pulse_d;
         valid_pulse_q <= valid_pulse_d;
         in_changed_q  <= in_changed_d;
         for (int i = 0; i < NCH; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign run_lvl     = lvl_q[0];
   assign step_lvl    = lvl_q[1];
   assign valid_lvl   = lvl_q[2];
   assign in_lvl      = lvl_q[7:3];
   assign step_pulse  = step_pulse_q;
   assign valid_pulse = valid_pulse_q;
   assign in_changed  = in_changed_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner: stimulus queues expected output changes (edge number, signal,
// value); a negedge monitor pops one entry for every output change it observes.
module tb_input_conditioner;

   logic       clk;
   logic       rst;
   logic       run, step, valid;
   logic [4:0] in;
   logic       run_lvl, step_lvl, step_pulse, valid_lvl, valid_pulse, in_changed;
   logic [4:0] in_lvl;

   input_conditioner #(.DEBOUNCE_CYCLES(4)) dut (
      .clk(clk), .rst(rst), .run(run), .step(step), .valid(valid), .in(in),
      .run_lvl(run_lvl), .step_lvl(step_lvl), .step_pulse(step_pulse),
      .valid_lvl(valid_lvl), .valid_pulse(valid_pulse), .in_lvl(in_lvl),
      .in_changed(in_changed)
   );

   typedef struct {
      int cyc;
      int id;
      int val;
   } evt_t;

   evt_t q[$];
   int   tests = 0;
   int   fails = 0;
   int   edge_n = 0;
   int   cur_v [7];
   int   prev_v [7] = '{default: 0};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) edge_n <= edge_n + 1;

   // ids: 0 run_lvl, 1 step_lvl, 2 step_pulse, 3 valid_lvl, 4 valid_pulse, 5 in_lvl, 6 in_changed
   function automatic void expect_evt(int c, int id, int v);
      evt_t e;
      e.cyc = c;
      e.id  = id;
      e.val = v;
      q.push_back(e);
   endfunction

   task automatic check_evt(int id, int v);
      evt_t e;
      tests++;
      if (q.size() == 0) begin
         fails++;
         $display("FAIL unexpected_change: id=%0d val=%0d at edge %0d, nothing expected", id, v, edge_n);
      end else begin
         e = q.pop_front();
         if (e.cyc != edge_n || e.id != id || e.val != v) begin
            fails++;
            $display("FAIL output_event: got id=%0d val=%0d edge=%0d, expected id=%0d val=%0d edge=%0d",
                     id, v, edge_n, e.id, e.val, e.cyc);
         end
      end
   endtask

   task automatic chk(string nm, int act, int expv);
      tests++;
      if (act != expv) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, expv);
      end
   endtask

   always @(negedge clk) begin
      cur_v[0] = int'(run_lvl);
      cur_v[1] = int'(step_lvl);
      cur_v[2] = int'(step_pulse);
      cur_v[3] = int'(valid_lvl);
      cur_v[4] = int'(valid_pulse);
      cur_v[5] = int'(in_lvl);
      cur_v[6] = int'(in_changed);
      for (int id = 0; id < 7; id++) begin
         if (cur_v[id] != prev_v[id]) check_evt(id, cur_v[id]);
         prev_v[id] = cur_v[id];
      end
   end

   task automatic tick(int n);
      repeat (n) @(negedge clk);
   endtask

   int e, e2;

   initial begin
      run = 0; step = 0; valid = 0; in = '0; rst = 1'b0;
      #1 rst = 1'b1;

      // Reset held with inputs toggling: nothing may leave the block.
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         run = i[0]; step = ~i[0]; valid = i[1]; in = 5'(i * 7);
         #1;
         chk("rst_hold", int'({run_lvl, step_lvl, step_pulse, valid_lvl, valid_pulse, in_lvl, in_changed}), 0);
      end
      @(negedge clk);
      run = 0; step = 0; valid = 0; in = '0;
      @(negedge clk);
      rst = 1'b0;
      tick(4);

      // Clean press then release of step.
      e = edge_n + 1; step = 1;
      expect_evt(e + 5, 1, 1); expect_evt(e + 6, 2, 1); expect_evt(e + 7, 2, 0);
      tick(10);
      e = edge_n + 1; step = 0;
      expect_evt(e + 5, 1, 0);
      tick(10);

      // Bouncing valid settling high: one pulse only.
      valid = 1; tick(2); valid = 0; tick(2); valid = 1; tick(2); valid = 0; tick(2);
      e = edge_n + 1; valid = 1;
      expect_evt(e + 5, 3, 1); expect_evt(e + 6, 4, 1); expect_evt(e + 7, 4, 0);
      tick(10);
      // Three-cycle low glitch is rejected.
      valid = 0; tick(3); valid = 1; tick(10);
      // Four-cycle low run is exactly long enough to be accepted.
      e = edge_n + 1; valid = 0;
      expect_evt(e + 5, 3, 0);
      tick(4);
      e2 = edge_n + 1; valid = 1;
      expect_evt(e2 + 5, 3, 1); expect_evt(e2 + 6, 4, 1); expect_evt(e2 + 7, 4, 0);
      tick(10);

      // Data bus: multi-bit step, then staggered single-bit changes.
      e = edge_n + 1; in = 5'b10101;
      expect_evt(e + 5, 5, 21); expect_evt(e + 6, 6, 1); expect_evt(e + 7, 6, 0);
      tick(10);
      e = edge_n + 1; in = 5'b10100;
      expect_evt(e + 5, 5, 20); expect_evt(e + 6, 6, 1); expect_evt(e + 7, 6, 0);
      tick(10);
      e = edge_n + 1; in = 5'b10110;
      expect_evt(e + 5, 5, 22); expect_evt(e + 6, 6, 1); expect_evt(e + 7, 6, 0);
      tick(10);

      // Reset mid-count, then inputs held high across release.
      run = 1; step = 1;
      tick(3);
      @(posedge clk);
      #2;
      expect_evt(edge_n, 3, 0); expect_evt(edge_n, 5, 0);
      rst = 1'b1;
      #1;
      chk("async_rst_valid_lvl", int'(valid_lvl), 0);
      chk("async_rst_in_lvl", int'(in_lvl), 0);
      chk("async_rst_step_lvl", int'(step_lvl), 0);
      tick(2);
      rst = 1'b0;
      e = edge_n + 1;
      expect_evt(e + 5, 0, 1); expect_evt(e + 5, 1, 1); expect_evt(e + 5, 3, 1); expect_evt(e + 5, 5, 22);
      expect_evt(e + 6, 2, 1); expect_evt(e + 6, 4, 1); expect_evt(e + 6, 6, 1);
      expect_evt(e + 7, 2, 0); expect_evt(e + 7, 4, 0); expect_evt(e + 7, 6, 0);
      tick(10);

      // Independence: run chatters every cycle while step/valid move together.
      e = edge_n + 1; step = 0; valid = 0;
      expect_evt(e + 5, 1, 0); expect_evt(e + 5, 3, 0);
      for (int i = 0; i < 10; i++) begin
         run = ~run;
         tick(1);
      end
      e = edge_n + 1; step = 1; valid = 1;
      expect_evt(e + 5, 1, 1); expect_evt(e + 5, 3, 1);
      expect_evt(e + 6, 2, 1); expect_evt(e + 6, 4, 1);
      expect_evt(e + 7, 2, 0); expect_evt(e + 7, 4, 0);
      for (int i = 0; i < 10; i++) begin
         run = ~run;
         tick(1);
      end
      e = edge_n + 1; run = 0;
      expect_evt(e + 5, 0, 0);
      tick(10);

      tests++;
      if (q.size() != 0) begin
         fails++;
         $display("FAIL missing_events: %0d expected output changes never seen, first at edge %0d",
                  q.size(), q[0].cyc);
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/input_conditioner.md
# input_conditioner

Front-end conditioning stage placed directly upstream of the PDU: takes the raw board switches and buttons (`run`, `step`, `valid`, `in[4:0]`) and delivers clean, clock-synchronous, debounced levels plus single-cycle press pulses. It runs on the divided system clock, the same `clk` that drives the PDU, so every PDU input is metastability-free and bounce-free. It is purely an input path and never touches CPU or memory state.

## Interface
- `DEBOUNCE_CYCLES`, default 250000; number of consecutive cycles a synchronized input must hold a new value before it is accepted. Legal range is 2 or more; 250000 is 20 ms at 12.5 MHz.
- `clk`  input  1  system clock (divided board clock, same as PDU `clk`)
- `rst`  input  1  reset, asynchronous, active-high
- `run`  input  1  raw run switch
- `step`  input  1  raw step button
- `valid`  input  1  raw valid button
- `in`  input  5  raw data switches
- `run_lvl`  output  1  debounced run level
- `step_lvl`  output  1  debounced step level
- `step_pulse`  output  1  one-cycle pulse on debounced step 0→1
- `valid_lvl`  output  1  debounced valid level
- `valid_pulse`  output  1  one-cycle pulse on debounced valid 0→1
- `in_lvl`  output  5  debounced data switches
- `in_changed`  output  1  one-cycle pulse when any `in_lvl` bit changed

## Operation
- There are 8 independent channels: run, step, valid, and in[0..4]. Each channel has the same structure:
  - 2-flop synchronizer `s1`→`s2`.
  - Stable register `lvl`.
  - Counter `cnt`, width `$clog2(DEBOUNCE_CYCLES)`.
- Per channel, at each `clk` rising edge:
  - If `s2 == lvl`: `cnt <= 0`.
  - Else if `cnt == DEBOUNCE_CYCLES-1`: `lvl <= s2`, `cnt <= 0`.
  - Else: `cnt <= cnt + 1`.
- A mismatch run shorter than `DEBOUNCE_CYCLES` edges (glitch or bounce) restarts the count and never changes `lvl`. The counter never wraps; it saturates only by the accept rule.
- `step_pulse` and `valid_pulse` are registered as `pulse <= lvl & ~lvl_d`, where `lvl_d` is `lvl` delayed one cycle. Each pulse is high for exactly one cycle per accepted rising edge. Falling edges produce no pulse.
- `in_changed` is registered as `|(in_lvl ^ in_lvl_d)`. It is one cycle high per edge at which at least one bit was accepted, even if several bits are accepted on the same edge.
- `run` gets a level output only, no pulse.
- There is no cross-channel interaction. Simultaneous changes on different channels are each handled independently.

## Timing
- Reset (async, immediate): all `s1`, `s2`, `lvl`, `lvl_d`, `cnt`, `in_lvl_d` go to 0. All outputs are 0 while `rst` is high and on the first edge after release.
- Level latency: if a raw input changes before edge E and then holds:
  - `s2` shows the new value after edge E+1.
  - `lvl` updates at edge E+1+`DEBOUNCE_CYCLES`.
- Pulse latency: `step_pulse`, `valid_pulse` and `in_changed` go high at edge E+2+`DEBOUNCE_CYCLES` and low again on the next edge.
- Raw input high during reset release: the channel starts from `lvl=0` and accepts the 1 after the normal latency, so one pulse is produced (intended: a held button reads as one press).
- Reset asserted mid-count: the count is lost. After release, counting restarts from 0 with `lvl=0`.
- Toggle exactly at the count limit: the value sampled in `s2` at the accepting edge decides. If `s2` returned to `lvl` on that edge, there is no accept.
- Pulse rate limit: back-to-back pulses on one channel are separated by at least 2×`DEBOUNCE_CYCLES` cycles (rise plus fall acceptance).

## Test plan
All scenarios use `DEBOUNCE_CYCLES=4`.
- Reset: hold `rst`=1 with all raw inputs toggling → every output stays 0. Assert `rst` mid-count → `cnt`/`lvl` clear with no clock edge.
- Clean press: `step` 0→1 before edge 0, then held → `step_lvl`=1 after edge 5, `step_pulse`=1 for exactly the cycle after edge 6, and 0 at edge 7. Release → `step_lvl`=0 after the same latency, with no pulse.
- Bounce: `valid` toggles 1,0,1,0 every 2 cycles, then settles at 1 → exactly one `valid_pulse`, occurring 6 edges after the last toggle. A 3-cycle-wide glitch gives no change.
- Data bus: `in` 5'b00000→5'b10101 in one step → `in_lvl`=5'b10101 after edge 5, with a single `in_changed` pulse. Staggered bit changes 10 cycles apart → two `in_changed` pulses.
- Held at reset release: `run`=1 and `step`=1 during reset, then release → `run_lvl`=1 and `step_lvl`=1 after edge 5 post-release, and one `step_pulse` at edge 6.
- Independence: `step` and `valid` pressed on the same cycle → both pulses fire on the same cycle. `run` toggling has no effect on the other channels.
